// File: rtl/eop_seq_detect.sv
// USB end-of-packet detector. Synchronises D+/D- into the clk domain and
// flags synced SE0 on eop_raw. A valid EOP is a run of SE0 samples of
// bounded length followed by J_MIN J samples. A valid EOP produces a
// one-cycle eop pulse and the SE0 run length on se0_len. A malformed
// sequence produces a one-cycle se0_err pulse.
module eop_seq_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int SE0_MIN     = 2,
    parameter int SE0_MAX     = 4,
    parameter int J_MIN       = 1,
    localparam int CNT_W      = $clog2(SE0_MAX + 2)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_plus,
    input  logic             d_minus,
    input  logic             enable,
    output logic             eop_raw,
    output logic             eop,
    output logic             se0_err,
    output logic [CNT_W-1:0] se0_len,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SE0_CNT = 2'd1;
    localparam logic [1:0] ST_J_CHK   = 2'd2;
    localparam logic [1:0] ST_ERR     = 2'd3;

    localparam int JCNT_W = (J_MIN < 2) ? 1 : $clog2(J_MIN + 1);

    localparam logic [CNT_W-1:0]  SE0_MIN_C = CNT_W'(SE0_MIN);
    localparam logic [CNT_W-1:0]  SE0_MAX_C = CNT_W'(SE0_MAX);
    localparam logic [CNT_W-1:0]  SE0_SAT_C = CNT_W'(SE0_MAX + 1);
    localparam logic [JCNT_W-1:0] J_MIN_C   = JCNT_W'(J_MIN);

    logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d;
    logic [SYNC_STAGES-1:0] dm_sync_q, dm_sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       scnt_q, scnt_d;
    logic [JCNT_W-1:0]      jcnt_q, jcnt_d;
    logic [JCNT_W-1:0]      jcnt_inc;
    logic [CNT_W-1:0]       len_q, len_d;
    logic                   eop_q, eop_d;
    logic                   err_q, err_d;

    logic dp_s, dm_s;
    logic line_se0, line_j;

    // Shift raw lines into the synchroniser chains.
    always_comb begin
        dp_sync_d = {dp_sync_q[SYNC_STAGES-2:0], d_plus};
        dm_sync_d = {dm_sync_q[SYNC_STAGES-2:0], d_minus};
    end

    assign dp_s     = dp_sync_q[SYNC_STAGES-1];
    assign dm_s     = dm_sync_q[SYNC_STAGES-1];
    assign line_se0 = ~dp_s & ~dm_s;
    assign line_j   = dp_s & ~dm_s;
    assign jcnt_inc = jcnt_q + 1'b1;

    // EOP sequence FSM: one decision per synced sample; pulses default low.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        jcnt_d  = jcnt_q;
        len_d   = len_q;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            scnt_d  = '0;
            jcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (line_se0) begin
                        state_d = ST_SE0_CNT;
                        scnt_d  = CNT_W'(1);
                        jcnt_d  = '0;
                    end
                end
                ST_SE0_CNT: begin
                    if (line_se0) begin
                        if (scnt_q >= SE0_MAX_C) begin
                            // Run is now longer than SE0_MAX; counter saturates.
                            state_d = ST_ERR;
                            scnt_d  = SE0_SAT_C;
                            err_d   = 1'b1;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end else if (line_j) begin
                        if (scnt_q >= SE0_MIN_C) begin
                            if (J_MIN == 1) begin
                                state_d = ST_IDLE;
                                eop_d   = 1'b1;
                                len_d   = scnt_q;
                                scnt_d  = '0;
                            end else begin
                                state_d = ST_J_CHK;
                                jcnt_d  = JCNT_W'(1);
                            end
                        end else begin
                            // Too short to be an EOP: treat as a line glitch.
                            state_d = ST_IDLE;
                            scnt_d  = '0;
                        end
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                ST_J_CHK: begin
                    if (line_j) begin
                        if (jcnt_inc >= J_MIN_C) begin
                            state_d = ST_IDLE;
                            eop_d   = 1'b1;
                            len_d   = scnt_q;
                            scnt_d  = '0;
                            jcnt_d  = '0;
                        end else begin
                            jcnt_d = jcnt_inc;
                        end
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    // ST_ERR: wait for idle J before accepting a new sequence.
                    if (line_j) begin
                        state_d = ST_IDLE;
                        scnt_d  = '0;
                        jcnt_d  = '0;
                    end
                end
            endcase
        end
    end

    // State registers; synchronisers reset to the J (idle) line state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync_q <= '1;
            dm_sync_q <= '0;
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            jcnt_q    <= '0;
            len_q     <= '0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dp_sync_q <= dp_sync_d;
            dm_sync_q <= dm_sync_d;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            jcnt_q    <= jcnt_d;
            len_q     <= len_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
        end
    end

    assign eop_raw   = line_se0;
    assign eop       = eop_q;
    assign se0_err   = err_q;
    assign se0_len   = len_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_eop_seq_detect.sv
// Directed bench for eop_seq_detect. Raw symbols are applied before each
// rising edge; outputs are recorded 1 time unit after it. A raw sample
// applied at step k shows on eop_raw at step k+1 and its FSM decision shows
// on eop/se0_err at step k+2.
module tb_eop_seq_detect;

    localparam logic [1:0] SJ = 2'b10;
    localparam logic [1:0] SK = 2'b01;
    localparam logic [1:0] S0 = 2'b00;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SE0_CNT = 2'd1;
    localparam logic [1:0] ST_ERR     = 2'd3;

    logic       clk;
    logic       n_rst;
    logic       d_plus;
    logic       d_minus;
    logic       enable;
    logic       eop_raw, eop, se0_err;
    logic [2:0] se0_len;
    logic [1:0] dbg_state;
    logic       eop_raw2, eop2, se0_err2;
    logic [2:0] se0_len2;
    logic [1:0] dbg_state2;

    int n_vec;
    int n_bad;

    logic       raw_h[$];
    logic       eop_h[$];
    logic       err_h[$];
    logic [2:0] len_h[$];
    logic [1:0] st_h[$];
    logic       eop2_h[$];
    logic [2:0] len2_h[$];

    eop_seq_detect dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
        .enable(enable), .eop_raw(eop_raw), .eop(eop), .se0_err(se0_err),
        .se0_len(se0_len), .dbg_state(dbg_state)
    );

    eop_seq_detect #(.J_MIN(2)) dut_j2 (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
        .enable(enable), .eop_raw(eop_raw2), .eop(eop2), .se0_err(se0_err2),
        .se0_len(se0_len2), .dbg_state(dbg_state2)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one raw sample, advance one cycle and record the outputs.
    task automatic step(input logic [1:0] sym, input logic en);
        d_plus  = sym[1];
        d_minus = sym[0];
        enable  = en;
        @(posedge clk);
        #1;
        raw_h.push_back(eop_raw);
        eop_h.push_back(eop);
        err_h.push_back(se0_err);
        len_h.push_back(se0_len);
        st_h.push_back(dbg_state);
        eop2_h.push_back(eop2);
        len2_h.push_back(se0_len2);
    endtask

    task automatic test_reset();
        int b;
        b = eop_h.size();
        step(S0, 1'b1);
        step(S0, 1'b1);
        #2 n_rst = 1'b1;
        step(SJ, 1'b1);
        step(SJ, 1'b1);
        step(SJ, 1'b1);
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({raw_h[b+k], eop_h[b+k], err_h[b+k], len_h[b+k], st_h[b+k]} !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_idle step %0d: raw/eop/err/len/st=%b%b%b_%0d_%0d required all 0",
                         k, raw_h[b+k], eop_h[b+k], err_h[b+k], len_h[b+k], st_h[b+k]);
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic [1:0] seq[6] = '{SJ, SJ, S0, S0, S0, S0};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 6; k++) step(seq[k], 1'b1);
        n_vec++;
        if (st_h[b+5] !== ST_SE0_CNT) begin
            n_bad++;
            $display("FAIL mid_rst_pre state=%0d required %0d", st_h[b+5], ST_SE0_CNT);
        end
        #2 n_rst = 1'b0;
        #1;
        n_vec++;
        if ({eop_raw, eop, se0_err, se0_len, dbg_state} !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_rst_async raw/eop/err/len/st=%b%b%b_%0d_%0d required all 0",
                     eop_raw, eop, se0_err, se0_len, dbg_state);
        end
        d_plus  = 1'b1;
        d_minus = 1'b0;
        #2 n_rst = 1'b1;
        b = eop_h.size();
        for (int k = 0; k < 6; k++) step(SJ, 1'b1);
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if ({eop_h[b+k], err_h[b+k]} !== 2'b00) begin
                n_bad++;
                $display("FAIL mid_rst_release step %0d eop=%b err=%b required 0 0", k, eop_h[b+k], err_h[b+k]);
            end
        end
    endtask

    task automatic test_valid_eop();
        logic [1:0] seq[9] = '{SJ, SJ, S0, S0, S0, SJ, SJ, SJ, SJ};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 9; k++) step(seq[k], 1'b1);
        for (int k = 0; k < 9; k++) begin
            n_vec++;
            if (raw_h[b+k] !== (k >= 3 && k <= 5)) begin
                n_bad++;
                $display("FAIL valid_raw step %0d got %b required %b", k, raw_h[b+k], (k >= 3 && k <= 5));
            end
            n_vec++;
            if ({eop_h[b+k], err_h[b+k]} !== {(k == 7), 1'b0}) begin
                n_bad++;
                $display("FAIL valid_eop step %0d eop=%b err=%b required %b 0", k, eop_h[b+k], err_h[b+k], (k == 7));
            end
        end
        n_vec++;
        if (len_h[b+8] !== 3'd3) begin
            n_bad++;
            $display("FAIL valid_len got %0d required 3", len_h[b+8]);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] seq[6] = '{SJ, S0, SJ, SJ, SJ, SJ};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 6; k++) step(seq[k], 1'b1);
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if ({eop_h[b+k], err_h[b+k]} !== 2'b00) begin
                n_bad++;
                $display("FAIL glitch_pulse step %0d eop=%b err=%b required 0 0", k, eop_h[b+k], err_h[b+k]);
            end
        end
        n_vec++;
        if (st_h[b+3] !== ST_SE0_CNT || st_h[b+4] !== ST_IDLE) begin
            n_bad++;
            $display("FAIL glitch_state got %0d,%0d required %0d,%0d", st_h[b+3], st_h[b+4], ST_SE0_CNT, ST_IDLE);
        end
        n_vec++;
        if (len_h[b+5] !== 3'd3) begin
            n_bad++;
            $display("FAIL glitch_len got %0d required 3", len_h[b+5]);
        end
    endtask

    task automatic test_se0_too_long();
        logic [1:0] seq[10] = '{SJ, S0, S0, S0, S0, S0, SJ, SJ, SJ, SJ};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 10; k++) step(seq[k], 1'b1);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if ({eop_h[b+k], err_h[b+k]} !== {1'b0, (k == 7)}) begin
                n_bad++;
                $display("FAIL long_pulse step %0d eop=%b err=%b required 0 %b", k, eop_h[b+k], err_h[b+k], (k == 7));
            end
        end
        n_vec++;
        if (st_h[b+7] !== ST_ERR || st_h[b+8] !== ST_IDLE) begin
            n_bad++;
            $display("FAIL long_state got %0d,%0d required %0d,%0d", st_h[b+7], st_h[b+8], ST_ERR, ST_IDLE);
        end
    endtask

    task automatic test_k_error_then_eop();
        logic [1:0] seq[13] = '{SJ, S0, S0, SK, SK, SK, SJ, S0, S0, SJ, SJ, SJ, SJ};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 13; k++) step(seq[k], 1'b1);
        for (int k = 0; k < 13; k++) begin
            n_vec++;
            if ({eop_h[b+k], err_h[b+k]} !== {(k == 11), (k == 5)}) begin
                n_bad++;
                $display("FAIL kerr_pulse step %0d eop=%b err=%b required %b %b",
                         k, eop_h[b+k], err_h[b+k], (k == 11), (k == 5));
            end
        end
        n_vec++;
        if (st_h[b+7] !== ST_ERR || st_h[b+8] !== ST_IDLE) begin
            n_bad++;
            $display("FAIL kerr_state got %0d,%0d required %0d,%0d", st_h[b+7], st_h[b+8], ST_ERR, ST_IDLE);
        end
        n_vec++;
        if (len_h[b+12] !== 3'd2) begin
            n_bad++;
            $display("FAIL kerr_len got %0d required 2", len_h[b+12]);
        end
    endtask

    task automatic test_enable_abort();
        logic [1:0] seq[10] = '{SJ, S0, S0, S0, SJ, SJ, SJ, SJ, SJ, SJ};
        logic       en[10]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 10; k++) step(seq[k], en[k]);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if ({eop_h[b+k], err_h[b+k]} !== 2'b00) begin
                n_bad++;
                $display("FAIL enable_pulse step %0d eop=%b err=%b required 0 0", k, eop_h[b+k], err_h[b+k]);
            end
        end
        n_vec++;
        if (st_h[b+4] !== ST_SE0_CNT || st_h[b+5] !== ST_IDLE) begin
            n_bad++;
            $display("FAIL enable_state got %0d,%0d required %0d,%0d", st_h[b+4], st_h[b+5], ST_SE0_CNT, ST_IDLE);
        end
        n_vec++;
        if (len_h[b+9] !== 3'd2) begin
            n_bad++;
            $display("FAIL enable_len got %0d required 2", len_h[b+9]);
        end
    endtask

    task automatic test_j_min_two();
        logic [1:0] seq[8] = '{SJ, S0, S0, SJ, SJ, SJ, SJ, SJ};
        int b;
        b = eop_h.size();
        for (int k = 0; k < 8; k++) step(seq[k], 1'b1);
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (eop2_h[b+k] !== (k == 6)) begin
                n_bad++;
                $display("FAIL jmin2_eop step %0d got %b required %b", k, eop2_h[b+k], (k == 6));
            end
            n_vec++;
            if (eop_h[b+k] !== (k == 5)) begin
                n_bad++;
                $display("FAIL jmin1_eop step %0d got %b required %b", k, eop_h[b+k], (k == 5));
            end
        end
        n_vec++;
        if (len2_h[b+7] !== 3'd2) begin
            n_bad++;
            $display("FAIL jmin2_len got %0d required 2", len2_h[b+7]);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        n_rst   = 1'b0;
        enable  = 1'b1;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        test_reset();
        test_reset_mid_sequence();
        test_valid_eop();
        test_glitch();
        test_se0_too_long();
        test_k_error_then_eop();
        test_enable_abort();
        test_j_min_two();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
